// File: rtl/scm_lut_ctrl.sv
// Load/lookup sequencer in front of a latch-based LUT store (scm).
// Optional macro SCM_LUT_CTRL_RAW_BYPASS_EN: forward pending write data instead of stalling.
module scm_lut_ctrl #(
  parameter int unsigned C             = 32,
  parameter int unsigned K             = 16,
  parameter int unsigned DataTypeWidth = 16,
  localparam int unsigned TotalAddrWidth = $clog2(C * K)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_start_i,
  input  logic                      load_valid_i,
  input  logic [DataTypeWidth-1:0]  load_data_i,
  output logic                      load_ready_o,
  output logic                      load_busy_o,
  output logic                      load_done_o,
  input  logic                      rd_valid_i,
  input  logic [$clog2(C)-1:0]      rd_c_i,
  input  logic [$clog2(K)-1:0]      rd_k_i,
  output logic                      rd_ready_o,
  output logic                      rd_valid_o,
  output logic [DataTypeWidth-1:0]  rd_data_o,
  input  logic                      rd_ready_i,
  output logic [TotalAddrWidth-1:0] scm_raddr_o,
  input  logic [DataTypeWidth-1:0]  scm_rdata_i,
  output logic [TotalAddrWidth-1:0] scm_waddr_o,
  output logic [DataTypeWidth-1:0]  scm_wdata_o,
  output logic                      scm_we_o
);

  localparam int unsigned Entries = C * K;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [TotalAddrWidth-1:0] cnt_q, cnt_d;
  logic                      load_done_q, load_done_d;
  logic                      rd_valid_q;
  logic [DataTypeWidth-1:0]  rd_data_q, rd_data_d;
  logic [TotalAddrWidth-1:0] wr_addr_q;
  logic                      wr_pend_q;
  logic                      hazard;
  logic                      rd_accept;

  // Next-state, load counter and write-port drive
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_done_d  = 1'b0;
    load_ready_o = 1'b0;
    scm_we_o     = 1'b0;
    scm_waddr_o  = '0;
    scm_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        load_ready_o = 1'b1;
        scm_we_o     = load_valid_i;
        scm_waddr_o  = cnt_q;
        scm_wdata_o  = load_data_i;
        if (load_start_i) begin
          cnt_d = '0;
        end else if (load_valid_i) begin
          if (cnt_q == TotalAddrWidth'(Entries - 1)) begin
            state_d     = ACTIVE;
            cnt_d       = '0;
            load_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TotalAddrWidth'(1);
          end
        end
      end
      ACTIVE: begin
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
    end
  end

  assign load_busy_o = (state_q == LOAD);
  assign load_done_o = load_done_q;
  assign scm_raddr_o = {rd_c_i, rd_k_i};

`ifdef SCM_LUT_CTRL_RAW_BYPASS_EN
  // The scm commits one cycle late, so a matching read takes the in-flight data
  logic [DataTypeWidth-1:0] wr_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wr_data_q <= '0;
    else       wr_data_q <= scm_wdata_o;
  end

  assign hazard    = 1'b0;
  assign rd_data_d = (wr_pend_q && (scm_raddr_o == wr_addr_q)) ? wr_data_q : scm_rdata_i;
`else
  assign hazard    = wr_pend_q && (scm_raddr_o == wr_addr_q);
  assign rd_data_d = scm_rdata_i;
`endif

  // A pending LUT invalidation blocks new lookups in the same cycle
  assign rd_ready_o = (state_q == ACTIVE) && !load_start_i && !hazard &&
                      (!rd_valid_q || rd_ready_i);
  assign rd_accept  = rd_valid_i && rd_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_pend_q <= scm_we_o;
      wr_addr_q <= scm_waddr_o;
      if (rd_accept) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rd_data_d;
      end else if (rd_ready_i) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule
